// File: rtl/generic_func_pack.sv
// Shared helper functions used across the codebase.
// Kept tiny so any block can import it at elaboration time.
package generic_func_pack;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pkt_fifo_pkg.sv
// Types and helpers for the packet-aware FIFO.
// Write FSM states and pointer sizing.
package pkt_fifo_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST style streaming bundle with valid/ready handshake.
// master drives the payload, slave drives rdy.
interface avalon_st_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int EMPTY_WIDTH = 1
);

  logic [DATA_WIDTH-1:0]  data;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   sop;
  logic                   eop;
  logic                   vld;
  logic                   rdy;

  modport master (
    output data, empty, sop, eop, vld,
    input  rdy
  );

  modport slave (
    input  data, empty, sop, eop, vld,
    output rdy
  );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: synchronous write,
// combinational read.
module sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO: only complete, error-free
// packets reach the read side; bad packets are rolled back.
module pkt_fifo
  import pkt_fifo_pkg::*;
  import generic_func_pack::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int AF_THRESH      = FIFO_DEPTH - 2,
  parameter int AE_THRESH      = 1,
  parameter int DROP_CNT_WIDTH = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int EMPTY_WIDTH    = 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  avalon_st_if.slave                write,
  input  logic                      write_err,
  avalon_st_if.master               read,
  output logic [LVL_W-1:0]          fill_level,
  output logic [LVL_W-1:0]          pkt_cnt,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty
);

  localparam int PTR_W      = ptr_width(FIFO_DEPTH);
  localparam int META_WIDTH = EMPTY_WIDTH + 2;
  localparam int WORD_W     = DATA_WIDTH + META_WIDTH;

  localparam logic [PTR_W:0] DEPTH_LVL =
    (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] AF_LVL =
    (PTR_W+1)'(AF_THRESH);
  localparam logic [PTR_W:0] AE_LVL =
    (PTR_W+1)'(AE_THRESH);

  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 4) begin : g_depth_chk
    $error("pkt_fifo: FIFO_DEPTH must be a power of 2 >= 4");
  end

  wr_state_t state;
  wr_state_t state_nxt;

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] commit_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] wr_ptr_nxt;
  logic [PTR_W:0] commit_ptr_nxt;
  logic [PTR_W:0] used_lvl;
  logic [PTR_W:0] cmt_lvl;

  logic             cmt_zero;
  logic             oversize;
  logic             wr_fire;
  logic             rd_fire;
  logic             cmt_inc;
  logic [1:0]       drop_inc;
  logic             ram_we;
  logic [PTR_W-1:0] ram_waddr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;

  logic [DROP_CNT_WIDTH:0] drop_sum;

  assign used_lvl = wr_ptr - rd_ptr;
  assign cmt_lvl  = commit_ptr - rd_ptr;
  assign cmt_zero = (cmt_lvl == '0);

  assign fill_level   = LVL_W'(used_lvl);
  assign full         = (used_lvl == DEPTH_LVL);
  assign empty        = cmt_zero;
  assign almost_full  = (used_lvl >= AF_LVL);
  assign almost_empty = (cmt_lvl <= AE_LVL);

  // In WR_PKT a full FIFO with nothing committed can only mean
  // the current packet alone overflows storage.
  assign oversize = full & cmt_zero;

  always_comb begin
    write.rdy = ~full;
    unique case (state)
      WR_IDLE: write.rdy = ~full;
      WR_PKT:  write.rdy = ~full | cmt_zero;
      WR_DROP: write.rdy = 1'b1;
      default: write.rdy = ~full;
    endcase
  end

  assign wr_fire = write.vld & write.rdy;
  assign rd_fire = read.vld & read.rdy;

  assign wdata = {write.data, write.empty,
                  write.sop, write.eop};

  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    cmt_inc        = 1'b0;
    drop_inc       = 2'd0;
    ram_we         = 1'b0;
    ram_waddr      = wr_ptr[PTR_W-1:0];
    if (wr_fire) begin
      unique case (state)
        WR_IDLE: begin
          if (write.sop) begin
            ram_we = 1'b1;
            if (!write.eop) begin
              wr_ptr_nxt = wr_ptr + 1'b1;
              state_nxt  = WR_PKT;
            end else if (write_err) begin
              drop_inc = 2'd1;
            end else begin
              wr_ptr_nxt     = wr_ptr + 1'b1;
              commit_ptr_nxt = wr_ptr + 1'b1;
              cmt_inc        = 1'b1;
            end
          end
        end
        WR_PKT: begin
          if (write.sop) begin
            // Framing fault: restart the packet at commit_ptr.
            ram_we    = 1'b1;
            ram_waddr = commit_ptr[PTR_W-1:0];
            drop_inc  = 2'd1;
            if (!write.eop) begin
              wr_ptr_nxt = commit_ptr + 1'b1;
            end else if (write_err) begin
              wr_ptr_nxt = commit_ptr;
              drop_inc   = 2'd2;
              state_nxt  = WR_IDLE;
            end else begin
              wr_ptr_nxt     = commit_ptr + 1'b1;
              commit_ptr_nxt = commit_ptr + 1'b1;
              cmt_inc        = 1'b1;
              state_nxt      = WR_IDLE;
            end
          end else if (oversize) begin
            wr_ptr_nxt = commit_ptr;
            drop_inc   = 2'd1;
            state_nxt  = write.eop ? WR_IDLE : WR_DROP;
          end else begin
            ram_we = 1'b1;
            if (!write.eop) begin
              wr_ptr_nxt = wr_ptr + 1'b1;
            end else if (write_err) begin
              wr_ptr_nxt = commit_ptr;
              drop_inc   = 2'd1;
              state_nxt  = WR_IDLE;
            end else begin
              wr_ptr_nxt     = wr_ptr + 1'b1;
              commit_ptr_nxt = wr_ptr + 1'b1;
              cmt_inc        = 1'b1;
              state_nxt      = WR_IDLE;
            end
          end
        end
        WR_DROP: begin
          if (write.eop) state_nxt = WR_IDLE;
        end
        default: state_nxt = WR_IDLE;
      endcase
    end
  end

  assign drop_sum = {1'b0, drop_cnt} +
                    (DROP_CNT_WIDTH+1)'(drop_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WR_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      unique case ({cmt_inc, rd_fire & rdata[0]})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
      drop_cnt <= drop_sum[DROP_CNT_WIDTH] ? '1 :
                  drop_sum[DROP_CNT_WIDTH-1:0];
    end
  end

  sdp_ram #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (wdata),
    .raddr (rd_ptr[PTR_W-1:0]),
    .rdata (rdata)
  );

  assign read.data  = rdata[WORD_W-1 -: DATA_WIDTH];
  assign read.empty = rdata[2 +: EMPTY_WIDTH];
  assign read.sop   = rdata[1];
  assign read.eop   = rdata[0];
  assign read.vld   = ~cmt_zero;

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo at depth 8, AF 6, AE 1.
// Scenario tasks run in sequence from one initial block.
module tb_pkt_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic write_err = 1'b0;
  logic [3:0]  fill_level;
  logic [3:0]  pkt_cnt;
  logic [15:0] drop_cnt;
  logic full, empty, almost_full, almost_empty;

  int n_chk = 0;
  int n_err = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH(8), .EMPTY_WIDTH(1)) wr_if ();
  avalon_st_if #(.DATA_WIDTH(8), .EMPTY_WIDTH(1)) rd_if ();

  pkt_fifo #(
    .FIFO_DEPTH (8),
    .AF_THRESH  (6),
    .AE_THRESH  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write        (wr_if),
    .write_err    (write_err),
    .read         (rd_if),
    .fill_level   (fill_level),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  task automatic wr(input logic [7:0] d, input logic s,
                    input logic e, input logic er,
                    output logic to);
    wr_if.data = d;
    wr_if.sop  = s;
    wr_if.eop  = e;
    wr_if.vld  = 1'b1;
    write_err  = er;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (wr_if.rdy) begin
        @(posedge clk); #1;
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    wr_if.vld = 1'b0;
    wr_if.sop = 1'b0;
    wr_if.eop = 1'b0;
    write_err = 1'b0;
  endtask

  task automatic rd(output logic [7:0] d, output logic s,
                    output logic e, output logic to);
    rd_if.rdy = 1'b1;
    to = 1'b1;
    d = '0; s = 1'b0; e = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rd_if.vld) begin
        d = rd_if.data; s = rd_if.sop; e = rd_if.eop;
        @(posedge clk); #1;
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    rd_if.rdy = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_chk++; if (empty !== 1'b1) begin n_err++;
      $display("FAIL rst_empty: got %0b want 1", empty); end
    n_chk++; if (almost_empty !== 1'b1) begin n_err++;
      $display("FAIL rst_ae: got %0b want 1", almost_empty); end
    n_chk++; if (rd_if.vld !== 1'b0) begin n_err++;
      $display("FAIL rst_vld: got %0b want 0", rd_if.vld); end
    n_chk++; if (wr_if.rdy !== 1'b1) begin n_err++;
      $display("FAIL rst_rdy: got %0b want 1", wr_if.rdy); end
    n_chk++; if ({fill_level, pkt_cnt, drop_cnt} !== '0) begin
      n_err++;
      $display("FAIL rst_cnts: got %0h/%0h/%0h want 0",
               fill_level, pkt_cnt, drop_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_pkt;
    logic to, tos, s, e;
    logic [7:0] d;
    tos = 1'b0;
    wr(8'h11, 1, 0, 0, to); tos |= to;
    n_chk++; if (rd_if.vld !== 1'b0) begin n_err++;
      $display("FAIL t1_vld_w1: got %0b want 0", rd_if.vld); end
    wr(8'h12, 0, 0, 0, to); tos |= to;
    n_chk++; if (rd_if.vld !== 1'b0 || fill_level !== 4'd2) begin
      n_err++;
      $display("FAIL t1_pre_eop: got vld=%0b fill=%0d want 0/2",
               rd_if.vld, fill_level); end
    wr(8'h13, 0, 1, 0, to); tos |= to;
    n_chk++; if (rd_if.vld !== 1'b1 || pkt_cnt !== 4'd1 ||
                 fill_level !== 4'd3 || almost_empty !== 1'b0) begin
      n_err++;
      $display("FAIL t1_commit: got vld=%0b pc=%0d fill=%0d ae=%0b want 1/1/3/0",
               rd_if.vld, pkt_cnt, fill_level, almost_empty); end
    for (int i = 0; i < 3; i++) begin
      rd(d, s, e, to); tos |= to;
      n_chk++; if (d !== 8'h11 + 8'(i) || s !== (i == 0) ||
                   e !== (i == 2)) begin
        n_err++;
        $display("FAIL t1_rd%0d: got %0h s%0b e%0b want %0h",
                 i, d, s, e, 8'h11 + 8'(i)); end
      if (i == 1) begin
        n_chk++; if (almost_empty !== 1'b1 || pkt_cnt !== 4'd1) begin
          n_err++;
          $display("FAIL t1_ae1: got ae=%0b pc=%0d want 1/1",
                   almost_empty, pkt_cnt); end
      end
    end
    n_chk++; if (pkt_cnt !== 4'd0 || fill_level !== 4'd0 ||
                 empty !== 1'b1) begin
      n_err++;
      $display("FAIL t1_drain: got pc=%0d fill=%0d empty=%0b want 0/0/1",
               pkt_cnt, fill_level, empty); end
    n_chk++; if (tos !== 1'b0) begin n_err++;
      $display("FAIL t1_timeout: got %0b want 0", tos); end
  endtask

  task automatic test_err_drop;
    logic to, tos, s, e, vseen;
    logic [7:0] d;
    tos = 1'b0; vseen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr(8'h20 + 8'(i), i == 0, i == 3, i == 3, to);
      tos |= to; vseen |= rd_if.vld;
    end
    exp_drop = exp_drop + 1;
    n_chk++; if (vseen !== 1'b0 || fill_level !== 4'd0) begin
      n_err++;
      $display("FAIL t2_rollback: got vld=%0b fill=%0d want 0/0",
               vseen, fill_level); end
    n_chk++; if (drop_cnt !== 16'(exp_drop)) begin n_err++;
      $display("FAIL t2_drop: got %0d want %0d", drop_cnt, exp_drop); end
    wr(8'h28, 1, 0, 0, to); tos |= to;
    wr(8'h29, 0, 1, 0, to); tos |= to;
    for (int i = 0; i < 2; i++) begin
      rd(d, s, e, to); tos |= to;
      n_chk++; if (d !== 8'h28 + 8'(i) || e !== (i == 1)) begin
        n_err++;
        $display("FAIL t2_rd%0d: got %0h e%0b want %0h",
                 i, d, e, 8'h28 + 8'(i)); end
    end
    n_chk++; if (tos !== 1'b0) begin n_err++;
      $display("FAIL t2_timeout: got %0b want 0", tos); end
  endtask

  task automatic test_oversize;
    logic to, tos, s, e, stall;
    logic [7:0] d;
    logic [3:0] peak;
    tos = 1'b0; stall = 1'b0; peak = '0;
    for (int i = 0; i < 10; i++) begin
      stall |= ~wr_if.rdy;
      wr(8'h30 + 8'(i), i == 0, i == 9, 0, to); tos |= to;
      if (fill_level > peak) peak = fill_level;
    end
    exp_drop = exp_drop + 1;
    n_chk++; if (stall !== 1'b0) begin n_err++;
      $display("FAIL t3_rdy: got stall=%0b want 0", stall); end
    n_chk++; if (peak !== 4'd8 || fill_level !== 4'd0) begin
      n_err++;
      $display("FAIL t3_fill: got peak=%0d fill=%0d want 8/0",
               peak, fill_level); end
    n_chk++; if (drop_cnt !== 16'(exp_drop) || rd_if.vld !== 1'b0) begin
      n_err++;
      $display("FAIL t3_drop: got %0d vld=%0b want %0d/0",
               drop_cnt, rd_if.vld, exp_drop); end
    wr(8'h3A, 1, 0, 0, to); tos |= to;
    wr(8'h3B, 0, 1, 0, to); tos |= to;
    for (int i = 0; i < 2; i++) begin
      rd(d, s, e, to); tos |= to;
      n_chk++; if (d !== 8'h3A + 8'(i) || s !== (i == 0)) begin
        n_err++;
        $display("FAIL t3_rd%0d: got %0h s%0b want %0h",
                 i, d, s, 8'h3A + 8'(i)); end
    end
    n_chk++; if (tos !== 1'b0) begin n_err++;
      $display("FAIL t3_timeout: got %0b want 0", tos); end
  endtask

  task automatic test_full;
    logic to, tos, s, e, rseen;
    logic [7:0] d, x;
    tos = 1'b0; rseen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x = (i < 4) ? 8'h40 + 8'(i) : 8'h50 + 8'(i - 4);
      wr(x, i % 4 == 0, i % 4 == 3, 0, to); tos |= to;
      if (i == 4) begin
        n_chk++; if (almost_full !== 1'b0) begin n_err++;
          $display("FAIL t4_af5: got %0b want 0", almost_full); end
      end
      if (i == 5) begin
        n_chk++; if (almost_full !== 1'b1 || full !== 1'b0) begin
          n_err++;
          $display("FAIL t4_af6: got af=%0b full=%0b want 1/0",
                   almost_full, full); end
      end
    end
    n_chk++; if (full !== 1'b1 || almost_full !== 1'b1 ||
                 pkt_cnt !== 4'd2 || fill_level !== 4'd8) begin
      n_err++;
      $display("FAIL t4_full: got f=%0b af=%0b pc=%0d fill=%0d want 1/1/2/8",
               full, almost_full, pkt_cnt, fill_level); end
    wr_if.data = 8'h60; wr_if.sop = 1'b1; wr_if.vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rseen |= wr_if.rdy;
      @(posedge clk); #1;
    end
    wr_if.vld = 1'b0; wr_if.sop = 1'b0;
    n_chk++; if (rseen !== 1'b0 || fill_level !== 4'd8) begin
      n_err++;
      $display("FAIL t4_stall: got rdy=%0b fill=%0d want 0/8",
               rseen, fill_level); end
    for (int i = 0; i < 4; i++) begin
      rd(d, s, e, to); tos |= to;
      n_chk++; if (d !== 8'h40 + 8'(i)) begin n_err++;
        $display("FAIL t4_rdA%0d: got %0h want %0h",
                 i, d, 8'h40 + 8'(i)); end
    end
    n_chk++; if (wr_if.rdy !== 1'b1 || full !== 1'b0 ||
                 pkt_cnt !== 4'd1 || fill_level !== 4'd4) begin
      n_err++;
      $display("FAIL t4_reopen: got rdy=%0b f=%0b pc=%0d fill=%0d want 1/0/1/4",
               wr_if.rdy, full, pkt_cnt, fill_level); end
    for (int i = 0; i < 4; i++) begin
      wr(8'h60 + 8'(i), i == 0, i == 3, 0, to); tos |= to;
    end
    n_chk++; if (pkt_cnt !== 4'd2) begin n_err++;
      $display("FAIL t4_pc2: got %0d want 2", pkt_cnt); end
    for (int i = 0; i < 8; i++) begin
      x = (i < 4) ? 8'h50 + 8'(i) : 8'h60 + 8'(i - 4);
      rd(d, s, e, to); tos |= to;
      n_chk++; if (d !== x || e !== (i % 4 == 3)) begin n_err++;
        $display("FAIL t4_rdBC%0d: got %0h e%0b want %0h",
                 i, d, e, x); end
    end
    n_chk++; if (empty !== 1'b1 || tos !== 1'b0) begin n_err++;
      $display("FAIL t4_end: got empty=%0b to=%0b want 1/0",
               empty, tos); end
  endtask

  task automatic test_framing;
    logic to, tos, s, e;
    logic [7:0] d;
    tos = 1'b0;
    wr(8'h71, 1, 0, 0, to); tos |= to;
    wr(8'h72, 0, 0, 0, to); tos |= to;
    wr(8'h73, 0, 0, 0, to); tos |= to;
    wr(8'h81, 1, 0, 0, to); tos |= to;
    wr(8'h82, 0, 0, 0, to); tos |= to;
    wr(8'h83, 0, 1, 0, to); tos |= to;
    exp_drop = exp_drop + 1;
    n_chk++; if (drop_cnt !== 16'(exp_drop) || pkt_cnt !== 4'd1 ||
                 fill_level !== 4'd3) begin
      n_err++;
      $display("FAIL t5_state: got drop=%0d pc=%0d fill=%0d want %0d/1/3",
               drop_cnt, pkt_cnt, fill_level, exp_drop); end
    for (int i = 0; i < 3; i++) begin
      rd(d, s, e, to); tos |= to;
      n_chk++; if (d !== 8'h81 + 8'(i) || s !== (i == 0) ||
                   e !== (i == 2)) begin
        n_err++;
        $display("FAIL t5_rd%0d: got %0h s%0b e%0b want %0h",
                 i, d, s, e, 8'h81 + 8'(i)); end
    end
    n_chk++; if (rd_if.vld !== 1'b0 || tos !== 1'b0) begin n_err++;
      $display("FAIL t5_end: got vld=%0b to=%0b want 0/0",
               rd_if.vld, tos); end
  endtask

  task automatic test_reset_mid;
    logic to, tos, s, e;
    logic [7:0] d;
    tos = 1'b0;
    wr(8'h91, 1, 0, 0, to); tos |= to;
    wr(8'h92, 0, 1, 0, to); tos |= to;
    wr(8'hA1, 1, 0, 0, to); tos |= to;
    wr(8'hA2, 0, 0, 0, to); tos |= to;
    n_chk++; if (pkt_cnt !== 4'd1 || fill_level !== 4'd4) begin
      n_err++;
      $display("FAIL t6_pre: got pc=%0d fill=%0d want 1/4",
               pkt_cnt, fill_level); end
    rst_n = 1'b0;
    #1;
    exp_drop = 0;
    n_chk++; if (empty !== 1'b1 || almost_empty !== 1'b1 ||
                 rd_if.vld !== 1'b0 || wr_if.rdy !== 1'b1 ||
                 full !== 1'b0 || almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL t6_rst_flags: got e%0b ae%0b v%0b r%0b f%0b af%0b want 1 1 0 1 0 0",
               empty, almost_empty, rd_if.vld, wr_if.rdy,
               full, almost_full); end
    n_chk++; if ({fill_level, pkt_cnt, drop_cnt} !== '0) begin
      n_err++;
      $display("FAIL t6_rst_cnts: got %0d/%0d/%0d want 0",
               fill_level, pkt_cnt, drop_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rd_if.vld !== 1'b0) begin n_err++;
      $display("FAIL t6_stale: got vld=%0b want 0", rd_if.vld); end
    wr(8'hB1, 1, 1, 0, to); tos |= to;
    rd(d, s, e, to); tos |= to;
    n_chk++; if (d !== 8'hB1 || s !== 1'b1 || e !== 1'b1) begin
      n_err++;
      $display("FAIL t6_rd: got %0h s%0b e%0b want b1 1 1",
               d, s, e); end
    n_chk++; if (empty !== 1'b1 || tos !== 1'b0) begin n_err++;
      $display("FAIL t6_end: got empty=%0b to=%0b want 1/0",
               empty, tos); end
  endtask

  initial begin
    wr_if.data  = '0;
    wr_if.empty = '0;
    wr_if.sop   = 1'b0;
    wr_if.eop   = 1'b0;
    wr_if.vld   = 1'b0;
    rd_if.rdy   = 1'b0;
    test_reset();
    test_single_pkt();
    test_err_drop();
    test_oversize();
    test_full();
    test_framing();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pkt_fifo.md
Name: pkt_fifo

Overview:
- Packet-aware store-and-forward FIFO; next generation of the team's single-clock Avalon-ST FIFO.
- Adds packet drop on error, oversize or framing fault (write-pointer rollback), programmable almost-full/almost-empty flags, a packet count and a saturating drop counter.
- Sits between an Avalon-ST producer and consumer. Only complete, error-free packets are ever presented on the read side.

Parameters:
- FIFO_DEPTH, 16, storage words; must be a power of 2 and ≥ 4. A violation raises an elaboration $error via is_pow2.
- AF_THRESH, FIFO_DEPTH-2, almost_full asserts when used_level ≥ AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when committed_level ≤ AE_THRESH.
- DROP_CNT_WIDTH, 16, width of drop_cnt.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- write  avalon_st_if.slave  -  data/empty/sop/eop/vld/rdy. Word width = DATA_WIDTH + META_WIDTH.
- write_err  in  1  packet error flag; sampled only on an accepted eop word.
- read  avalon_st_if.master  -  output stream.
- fill_level  out  $clog2(FIFO_DEPTH+1)  used_level: committed words plus uncommitted words.
- pkt_cnt  out  $clog2(FIFO_DEPTH+1)  complete packets stored.
- drop_cnt  out  DROP_CNT_WIDTH  dropped packets; saturates at all-ones.
- full  out  1  used_level == FIFO_DEPTH.
- empty  out  1  committed_level == 0.
- almost_full  out  1  see AF_THRESH.
- almost_empty  out  1  see AE_THRESH.

Behaviour:
- Pointers: three (PTR_WIDTH+1)-bit pointers with natural wrap: wr_ptr, commit_ptr, rd_ptr. RAM address = pointer LSBs.
  - used_level = wr_ptr - rd_ptr.
  - committed_level = commit_ptr - rd_ptr.
- Reset: all pointers, counters and flags go to 0; FSM goes to WR_IDLE. Outputs at reset: empty=1, almost_empty=1, read.vld=0, write.rdy=1. Reset mid-packet discards all contents, including any partial packet.
- Storage: sdp_ram with synchronous write and combinational read at rd_ptr.
- Write FSM:
  - WR_IDLE:
    - rdy = ~full.
    - Accepted word with sop stores at wr_ptr. If eop is also set, it commits/drops as at eop; otherwise go to WR_PKT.
    - Accepted word without sop is discarded silently (nothing stored, no count).
  - WR_PKT:
    - rdy = ~full | (committed_level == 0). The second term is oversize detection.
    - Accepted non-sop word stores at wr_ptr and increments it.
    - On eop with write_err=0: commit_ptr <= wr_ptr+1, pkt_cnt+1, go to WR_IDLE.
    - On eop with write_err=1: wr_ptr <= commit_ptr, drop_cnt+1, go to WR_IDLE.
    - Oversize: full with committed_level==0 and vld=1. The word is accepted but not stored, wr_ptr <= commit_ptr, drop_cnt+1. If that word is eop, go to WR_IDLE; otherwise go to WR_DROP.
    - Framing fault (sop while in WR_PKT): partial packet rolled back, drop_cnt+1. The new sop word is stored at commit_ptr, wr_ptr <= commit_ptr+1; stay in WR_PKT, or handle as eop if the word also carries eop.
  - WR_DROP:
    - rdy = 1; words are consumed and not stored.
    - Accepted eop goes to WR_IDLE (no further count).
- Read side:
  - read.vld = committed_level > 0. The first word of a packet is visible the cycle after its eop handshake.
  - Read handshake increments rd_ptr; a read of an eop word decrements pkt_cnt.
- Simultaneous events:
  - Commit and eop-read in the same cycle leave pkt_cnt unchanged.
  - Rollback never touches the committed region, so it is safe concurrently with reads.
  - Read and write in the same cycle when full: a stalled write remains stalled that cycle, because rdy is computed from registered levels.
- Width rules: pkt_cnt never exceeds FIFO_DEPTH; flags are combinational from registered pointers.

Decomposition:
- generic_func_pack: is_pow2 (existing).
- New pkt_fifo_pack: wr_state_t enum {WR_IDLE, WR_PKT, WR_DROP} and a pointer-width helper function.
- Sub-module: reuse sdp_ram unchanged. Write FSM and pointer logic stay inline in pkt_fifo.

Test Plan (FIFO_DEPTH=8, AF_THRESH=6, AE_THRESH=1):
1. One 3-word packet (sop…eop, err=0) → read.vld=0 until 1 cycle after eop handshake; then 3 words in order; pkt_cnt 1→0, fill_level 3→0.
2. 4-word packet with write_err=1 on eop → read.vld never rises, fill_level returns 0, drop_cnt=1, following 2-word packet delivered intact.
3. 10-word packet into empty FIFO → write.rdy never deasserts, fill_level peaks 8 then drops to 0, drop_cnt=1, WR_IDLE after eop; next 2-word packet delivered.
4. Two 4-word packets, no reads → full=1, almost_full=1, third packet's sop sees rdy=0; reading one 4-word packet reopens rdy; pkt_cnt 2→1→2.
5. sop,w1,w2 then new sop (no eop) + 2 words + eop → drop_cnt=1, only the 3-word second packet emerges.
6. rst_n pulsed low mid-packet with one committed packet stored → all outputs at reset values immediately; no stale data is read after release.
